vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Raster timing generator and pixel output stage for the Pong display path. Produces the `CounterX`/`CounterY` scan coordinates consumed by `Ball_position`, the once-per-frame `calc_start` motion tick, and the VGA sync signals. It also gates the registered `draw_ball` strobe back into the RGB outputs, aligning sync with the one-cycle-late draw data. Default mode is 640x400 @ 70 Hz, matching the 640x400 playfield.

## Interface
- `CLK_DIV`, 2, system clocks per pixel; 1 = clock is already the 25.175 MHz pixel clock, 2 = 50 MHz board clock.
- `H_VIS`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48. Horizontal timing in pixels; total 800.
- `V_VIS`, 400; `V_FP`, 12; `V_SYNC`, 2; `V_BP`, 35. Vertical timing in lines; total 449.
- `H_POL`, 0, hsync active level; 0 = active low.
- `V_POL`, 1, vsync active level; 1 = active high.
- `clock` in 1: system clock. One clock domain only; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `draw_ball` in 1: registered ball hit for the pixel presented on the previous pixel slot.
- `CounterX` out 10: current column, 0..799.
- `CounterY` out 9: current line, 0..448.
- `inDisplayArea` out 1: high when CounterX < H_VIS and CounterY < V_VIS (unregistered decode of the counters).
- `calc_start` out 1: one-clock pulse, once per frame.
- `vga_h_sync` out 1; `vga_v_sync` out 1: sync outputs, delayed one pixel slot.
- `vga_R`, `vga_G`, `vga_B` out 1 each: pixel color, delayed one pixel slot.

## Operation
- Pixel enable `pix_en`: a mod-`CLK_DIV` divider counter. `pix_en` is high on the clock where the divider equals `CLK_DIV`-1. With `CLK_DIV`=1, `pix_en` is constant 1.
- Counters advance only on `pix_en`.
  - `CounterX` wraps from 799 to 0.
  - When `CounterX` wraps, `CounterY` increments; `CounterY` wraps from 448 to 0.
  - Both counters update in the same clock when the last pixel of the frame is reached.
- Raw hsync is active while `CounterX` is in [656, 751]. Raw vsync is active while `CounterY` is in [412, 413]. Apply `H_POL`/`V_POL` to the raw values.
- Output stage registers on `pix_en`. It delays raw hsync, raw vsync and `inDisplayArea` by one stage so they align with `draw_ball`.
  - If the delayed display enable is 1 and `draw_ball` is 1: RGB = 1,1,1 (white ball).
  - If the delayed display enable is 1 and `draw_ball` is 0: RGB = 0,0,0.
  - If the delayed display enable is 0 (blanking): RGB = 0,0,0, regardless of `draw_ball`.
- `calc_start` is asserted for exactly one `clock` cycle, on the `pix_en` clock where `CounterX`==0 and `CounterY`==V_VIS (400). This is the first blank line, so ball motion updates never tear the visible frame.
- Reset values: divider 0, `CounterX` 0, `CounterY` 0, `calc_start` 0, RGB 0, both syncs at their inactive level. Reset has priority over `pix_en`.
- Reset asserted mid-frame: everything returns to the reset values on the next edge. The first `calc_start` after release occurs at line 400 of the new frame.

## Timing
- `CounterX`/`CounterY` change one clock after the `pix_en` edge that advances them.
- Sync and RGB outputs lag their counter position by exactly one pixel slot (`CLK_DIV` clocks). `draw_ball` is sampled on the same `pix_en` edge that registers them.
- Frame period: 800 × 449 pixel slots = 359200 × `CLK_DIV` clocks, which is the spacing between `calc_start` pulses.
- Hsync width: 96 pixel slots. Vsync width: 2 lines (1600 slots).

## Structure
- Shared package `pong_pkg` holds the timing constants: H/V visible, porch and sync values, the derived totals, and the screen size used by `Ball_position` (640/400), so both blocks agree on geometry.
- One natural sub-module: `vga_pix_div`, the `CLK_DIV` clock-enable divider.
- The counters, sync decode and output stage stay in `vga_sync_gen`.

## Test plan
- Reset release, `CLK_DIV`=1: `CounterX` counts 0..799 and wraps to 0, and `CounterY` goes 0→1 on that same clock; syncs are inactive at reset.
- Full frame, `CLK_DIV`=2: `calc_start` pulses once, 1 clock wide, at X=0/Y=400. The next pulse arrives exactly 718400 clocks later.
- Sync check: `vga_h_sync` is low for 96 slots, starting one slot after X=656. `vga_v_sync` is high for 2 lines, starting one slot after line 412, X=0.
- `draw_ball` held 1 for the whole frame: RGB is 1 only for the delayed visible region (640×400 pixels) and 0 during all blanking.
- `reset` pulsed at X=300/Y=200: the next clock shows X=0, Y=0, RGB 0, syncs inactive. No `calc_start` appears until line 400.
- X=799/Y=448 boundary: both counters return to 0 on the same clock, and `calc_start` does not fire there.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared geometry for the Pong display path: raster timing used by the
// sync generator and the screen size used by the ball logic.
package pong_pkg;

  // System clocks per pixel slot (2 = 50 MHz board clock).
  localparam int VGA_CLK_DIV = 2;

  // Horizontal timing in pixels.
  localparam int VGA_H_VIS   = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing in lines.
  localparam int VGA_V_VIS   = 400;
  localparam int VGA_V_FP    = 12;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 35;
  localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync active levels for 640x400 @ 70 Hz: hsync low, vsync high.
  localparam bit VGA_H_POL = 1'b0;
  localparam bit VGA_V_POL = 1'b1;

  // Playfield size seen by Ball_position.
  localparam int SCREEN_W = VGA_H_VIS;
  localparam int SCREEN_H = VGA_V_VIS;

  // True when v lies in the half-open window [lo, lo+len).
  function automatic logic in_span(input int v, input int lo, input int len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-slot clock enable: one pulse every CLK_DIV system clocks.
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_srst,
  output logic o_pix_en
);

  generate
    if (CLK_DIV <= 1) begin : g_passthru
      // System clock already runs at the pixel rate.
      assign o_pix_en = 1'b1;
    end else begin : g_div
      localparam int W = $clog2(CLK_DIV);
      localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

      logic [W-1:0] r_div;

      // Modulo-CLK_DIV counter; the enable fires on its last count.
      always_ff @(posedge i_clk) begin
        if (i_srst) begin
          r_div <= '0;
        end else if (r_div == DIV_LAST) begin
          r_div <= '0;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end

      assign o_pix_en = (r_div == DIV_LAST);
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator and pixel output stage for the Pong display.
// Scan counters feed Ball_position; the returned draw_ball strobe is one
// slot late, so sync and display enable are delayed by one slot to match.
module vga_sync_gen
  import pong_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV,
  parameter int H_VIS   = VGA_H_VIS,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BP    = VGA_H_BP,
  parameter int V_VIS   = VGA_V_VIS,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BP    = VGA_V_BP,
  parameter bit H_POL   = VGA_H_POL,
  parameter bit V_POL   = VGA_V_POL
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       draw_ball,
  output logic [9:0] CounterX,
  output logic [8:0] CounterY,
  output logic       inDisplayArea,
  output logic       calc_start,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic       vga_R,
  output logic       vga_G,
  output logic       vga_B
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [8:0] Y_LAST = 9'(V_TOTAL - 1);
  // First blank line: moving the ball here never tears the visible frame.
  localparam logic [8:0] Y_CALC = 9'(V_VIS);

  logic       w_pix_en;
  logic       w_de;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic [9:0] r_x;
  logic [8:0] r_y;
  logic       r_hs;
  logic       r_vs;
  logic       r_rgb;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .i_clk    (clock),
    .i_srst   (reset),
    .o_pix_en (w_pix_en)
  );

  // Scan counters: X sweeps a line, Y steps when X wraps; both wrap together
  // on the last pixel of the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pix_en) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign w_de     = (int'(r_x) < H_VIS) && (int'(r_y) < V_VIS);
  assign w_hs_raw = in_span(int'(r_x), H_VIS + H_FP, H_SYNC);
  assign w_vs_raw = in_span(int'(r_y), V_VIS + V_FP, V_SYNC);

  // Output stage: one slot behind the counters so draw_ball lines up;
  // blanking forces black regardless of draw_ball.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hs  <= ~H_POL;
      r_vs  <= ~V_POL;
      r_rgb <= 1'b0;
    end else if (w_pix_en) begin
      r_hs  <= w_hs_raw ? H_POL : ~H_POL;
      r_vs  <= w_vs_raw ? V_POL : ~V_POL;
      r_rgb <= w_de & draw_ball;
    end
  end

  assign calc_start    = w_pix_en && (r_x == '0) && (r_y == Y_CALC);
  assign CounterX      = r_x;
  assign CounterY      = r_y;
  assign inDisplayArea = w_de;
  assign vga_h_sync    = r_hs;
  assign vga_v_sync    = r_vs;
  assign vga_R         = r_rgb;
  assign vga_G         = r_rgb;
  assign vga_B         = r_rgb;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size CLK_DIV=1 instance (line timing) and a
// shrunken CLK_DIV=2 instance with inverted polarities (whole frames, reset).
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } exp_t;

  // Instance 0 = fast (full timing), instance 1 = small (reduced timing).
  localparam int D    [2] = '{1, 2};
  localparam int HV   [2] = '{640, 16};
  localparam int HF   [2] = '{16, 2};
  localparam int HS   [2] = '{96, 4};
  localparam int HB   [2] = '{48, 3};
  localparam int VV   [2] = '{400, 10};
  localparam int VF   [2] = '{12, 2};
  localparam int VS   [2] = '{2, 2};
  localparam int VB   [2] = '{35, 3};
  localparam int HPOL [2] = '{0, 1};
  localparam int VPOL [2] = '{1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       db  [2];
  logic [9:0] ox  [2];
  logic [8:0] oy  [2];
  logic       ode [2];
  logic       ocs [2];
  logic       ohs [2];
  logic       ovs [2];
  logic       orr [2];
  logic       og  [2];
  logic       ob  [2];

  vga_sync_gen #(
    .CLK_DIV (1)
  ) u_fast (
    .clock         (clk),
    .reset         (rst[0]),
    .draw_ball     (db[0]),
    .CounterX      (ox[0]),
    .CounterY      (oy[0]),
    .inDisplayArea (ode[0]),
    .calc_start    (ocs[0]),
    .vga_h_sync    (ohs[0]),
    .vga_v_sync    (ovs[0]),
    .vga_R         (orr[0]),
    .vga_G         (og[0]),
    .vga_B         (ob[0])
  );

  vga_sync_gen #(
    .CLK_DIV (2),
    .H_VIS   (16),
    .H_FP    (2),
    .H_SYNC  (4),
    .H_BP    (3),
    .V_VIS   (10),
    .V_FP    (2),
    .V_SYNC  (2),
    .V_BP    (3),
    .H_POL   (1'b1),
    .V_POL   (1'b0)
  ) u_small (
    .clock         (clk),
    .reset         (rst[1]),
    .draw_ball     (db[1]),
    .CounterX      (ox[1]),
    .CounterY      (oy[1]),
    .inDisplayArea (ode[1]),
    .calc_start    (ocs[1]),
    .vga_h_sync    (ohs[1]),
    .vga_v_sync    (ovs[1]),
    .vga_R         (orr[1]),
    .vga_G         (og[1]),
    .vga_B         (ob[1])
  );

  int    tests_run    = 0;
  int    tests_failed = 0;
  int    n       [2];   // clocks since last reset edge
  exp_t  cur     [2];   // expected registered outputs right now
  exp_t  q0 [$];
  exp_t  q1 [$];
  int    last_cs [2];
  int    cs_seen [2];
  int    cyc;
  bit    mid_done;
  string nm [2] = '{"fast", "small"};

  task automatic chk(input string tag, input int obs, input int want);
    tests_run++;
    if (obs != want) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
    end
  endtask

  function automatic int ht(input int id);
    return HV[id] + HF[id] + HS[id] + HB[id];
  endfunction

  function automatic int vt(input int id);
    return VV[id] + VF[id] + VS[id] + VB[id];
  endfunction

  function automatic int pos_x(input int id, input int nn);
    return (nn / D[id]) % ht(id);
  endfunction

  function automatic int pos_y(input int id, input int nn);
    return ((nn / D[id]) / ht(id)) % vt(id);
  endfunction

  function automatic exp_t rst_val(input int id);
    exp_t e;
    e.hs  = 1'(HPOL[id] == 0);
    e.vs  = 1'(VPOL[id] == 0);
    e.rgb = 3'b000;
    return e;
  endfunction

  function automatic exp_t slot_val(input int id, input int x, input int y, input bit b);
    exp_t e;
    bit   hs_on;
    bit   vs_on;
    bit   de;
    hs_on = (x >= HV[id] + HF[id]) && (x < HV[id] + HF[id] + HS[id]);
    vs_on = (y >= VV[id] + VF[id]) && (y < VV[id] + VF[id] + VS[id]);
    de    = (x < HV[id]) && (y < VV[id]);
    e.hs  = hs_on ? 1'(HPOL[id]) : 1'(HPOL[id] == 0);
    e.vs  = vs_on ? 1'(VPOL[id]) : 1'(VPOL[id] == 0);
    e.rgb = (de && b) ? 3'b111 : 3'b000;
    return e;
  endfunction

  // Compare one instance's outputs against the timing model (at negedge).
  task automatic check_dut(input int id);
    int   x;
    int   y;
    bit   de;
    bit   cs;
    exp_t got;
    x  = pos_x(id, n[id]);
    y  = pos_y(id, n[id]);
    de = (x < HV[id]) && (y < VV[id]);
    cs = (((n[id] + 1) % D[id]) == 0) && (x == 0) && (y == VV[id]);
    chk($sformatf("%s_x", nm[id]), int'(ox[id]), x);
    chk($sformatf("%s_y", nm[id]), int'(oy[id]), y);
    chk($sformatf("%s_de", nm[id]), int'(ode[id]), int'(de));
    chk($sformatf("%s_calc", nm[id]), int'(ocs[id]), int'(cs));
    if (id == 0) begin
      if (q0.size() > 0) cur[0] = q0.pop_front();
    end else begin
      if (q1.size() > 0) cur[1] = q1.pop_front();
    end
    got = {ohs[id], ovs[id], orr[id], og[id], ob[id]};
    chk($sformatf("%s_hs", nm[id]), int'(got.hs), int'(cur[id].hs));
    chk($sformatf("%s_vs", nm[id]), int'(got.vs), int'(cur[id].vs));
    chk($sformatf("%s_rgb", nm[id]), int'(got.rgb), int'(cur[id].rgb));
    if (ocs[id] === 1'b1) begin
      cs_seen[id]++;
      if (last_cs[id] >= 0)
        chk($sformatf("%s_calc_gap", nm[id]), cyc - last_cs[id], ht(id) * vt(id) * D[id]);
      last_cs[id] = cyc;
    end
  endtask

  // Drive inputs for the next edge and queue what that edge must produce.
  task automatic drive_dut(input int id, input bit r, input bit b);
    exp_t e;
    bit   pen;
    pen     = ((n[id] + 1) % D[id]) == 0;
    rst[id] = r;
    db[id]  = b;
    if (r) begin
      e           = rst_val(id);
      n[id]       = 0;
      last_cs[id] = -1;
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end else begin
      if (pen) begin
        e = slot_val(id, pos_x(id, n[id]), pos_y(id, n[id]), b);
        if (id == 0) q0.push_back(e); else q1.push_back(e);
      end
      n[id]++;
    end
  endtask

  initial begin
    bit r1;
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    db[0]  = 1'b0;
    db[1]  = 1'b0;
    mid_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int id = 0; id < 2; id++) begin
      n[id]       = 0;
      cur[id]     = rst_val(id);
      last_cs[id] = -1;
      cs_seen[id] = 0;
    end
    $display("tb: reset held, checking reset state");
    for (cyc = 0; cyc < 3700; cyc++) begin
      if (cyc > 0) @(negedge clk);
      check_dut(0);
      check_dut(1);
      if (cyc == 3) $display("tb: reset released at cycle %0d", cyc);
      r1 = (cyc < 3);
      if (!mid_done && cyc > 1400 && pos_x(1, n[1]) == 7 && pos_y(1, n[1]) == 5) begin
        r1       = 1'b1;
        mid_done = 1'b1;
        $display("tb: mid-frame reset on small instance at X=7 Y=5, cycle %0d", cyc);
      end
      drive_dut(0, cyc < 3, 1'($urandom_range(0, 1)));
      drive_dut(1, r1, 1'($urandom_range(0, 1)));
    end
    chk("small_mid_reset_hit", int'(mid_done), 1);
    chk("small_calc_seen", int'(cs_seen[1] >= 3), 1);
    chk("fast_calc_seen", cs_seen[0], 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
